// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out > frame-clear engine > host port.
// Define VRAM_ARB_STATS_EN to build the host stall counter; otherwise it reads 0.
module vram_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 3,
   parameter int DEPTH  = 12288
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_value,
   output logic              clr_busy,
   input  logic              host_valid,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [15:0]       host_stall_cnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] FIRST_OOR = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

   clr_state_t        clr_state;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] clr_val_q;
   logic              tag_disp, tag_host, tag_oor;
   logic              host_oor, grant_clr, grant_host;

   assign clr_busy   = (clr_state == ST_CLEAR);
   assign host_oor   = (host_addr >= FIRST_OOR);
   assign grant_clr  = ~disp_req & clr_busy;
   assign grant_host = ~disp_req & ~clr_busy & host_valid;
   assign host_ready = grant_host;

   // Out-of-range host requests are still accepted, they just never touch the macro.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!reset) begin
         if (disp_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
         end else if (grant_clr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = clr_val_q;
         end else if (grant_host && !host_oor) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (reset) begin
         clr_state <= ST_IDLE;
         clr_addr  <= '0;
         clr_val_q <= '0;
      end else begin
         case (clr_state)
            ST_IDLE: begin
               if (clr_start) begin
                  clr_state <= ST_CLEAR;
                  clr_val_q <= clr_value;
                  clr_addr  <= '0;
               end
            end
            ST_CLEAR: begin
               // A display fetch steals the slot; the clear address holds.
               if (!disp_req) begin
                  if (clr_addr == LAST_ADDR) begin
                     clr_state <= ST_IDLE;
                     clr_addr  <= '0;
                  end else begin
                     clr_addr <= clr_addr + 1'b1;
                  end
               end
            end
            default: clr_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_disp <= 1'b0;
         tag_host <= 1'b0;
         tag_oor  <= 1'b0;
      end else begin
         tag_disp <= disp_req;
         tag_host <= grant_host & ~host_we;
         tag_oor  <= grant_host & ~host_we & host_oor;
      end
   end

   assign disp_rvalid = tag_disp;
   assign disp_rdata  = tag_disp ? mem_rdata : '0;
   assign host_rvalid = tag_host;
   assign host_rdata  = (tag_host && !tag_oor) ? mem_rdata : '0;

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (host_valid && !host_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign host_stall_cnt = stall_q;
`else
   assign host_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM model.
// Expected values are hand-computed constants; VRAM_ARB_STATS_EN selects the stall expectation.
module tb_vram_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 3;
   localparam int DEPTH  = 12288;
`ifdef VRAM_ARB_STATS_EN
   localparam int EXP_STALL = 3;
`else
   localparam int EXP_STALL = 0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_rvalid;
   logic [DATA_W-1:0] disp_rdata;
   logic              clr_start;
   logic [DATA_W-1:0] clr_value;
   logic              clr_busy;
   logic              host_valid;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ready;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic [15:0]       host_stall_cnt;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];

   int checks = 0;
   int errors = 0;

   vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
      .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ready(host_ready),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .host_stall_cnt(host_stall_cnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port VRAM macro model, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) vram[mem_addr] <= mem_wdata;
         else        mem_rdata      <= vram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int i = 0; i < (1 << ADDR_W); i++) vram[i] = DATA_W'(i);
   endtask

   int cyc;
   int disp_cnt;
   int bad;

   initial begin
      preload();
      mem_rdata  = '0;
      reset      = 1'b1;
      disp_req   = 1'b1;
      disp_addr  = 14'd9;
      clr_start  = 1'b0;
      clr_value  = '0;
      host_valid = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;

      // Reset state: memory port quiet even with a display request pending.
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_clr_busy", clr_busy, 0);
      check("rst_disp_rvalid", disp_rvalid, 0);
      check("rst_host_rvalid", host_rvalid, 0);
      check("rst_stall", host_stall_cnt, 0);
      tick();
      disp_req = 1'b0;
      reset    = 1'b0;
      tick();

      // Display-only reads of addresses 0..4.
      for (int i = 0; i < 5; i++) begin
         disp_req  = 1'b1;
         disp_addr = 14'(i);
         #1;
         check("disp_mem_en", mem_en, 1);
         check("disp_mem_we", mem_we, 0);
         check("disp_mem_addr", mem_addr, i);
         if (i > 0) begin
            check("disp_rvalid", disp_rvalid, 1);
            check("disp_rdata", disp_rdata, i - 1);
         end
         tick();
      end
      disp_req = 1'b0;
      #1;
      check("disp_rvalid_last", disp_rvalid, 1);
      check("disp_rdata_last", disp_rdata, 4);
      check("disp_no_host_rvalid", host_rvalid, 0);
      tick();
      check("disp_rvalid_drop", disp_rvalid, 0);
      check("disp_rdata_zero", disp_rdata, 0);

      // Host write 100 <= 3'b101 then read it back.
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = 14'd100;
      host_wdata = 3'b101;
      #1;
      check("hw_ready", host_ready, 1);
      check("hw_mem_en", mem_en, 1);
      check("hw_mem_we", mem_we, 1);
      check("hw_mem_wdata", mem_wdata, 3'b101);
      tick();
      check("hw_no_rvalid", host_rvalid, 0);
      host_we = 1'b0;
      #1;
      check("hr_ready", host_ready, 1);
      check("hr_mem_we", mem_we, 0);
      tick();
      host_valid = 1'b0;
      #1;
      check("hr_rvalid", host_rvalid, 1);
      check("hr_rdata", host_rdata, 3'b101);
      check("hr_no_disp_rvalid", disp_rvalid, 0);
      tick();

      // Display/host collision: host stalls 3 cycles, accepted on the 4th.
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = 14'd7;
      disp_addr  = 14'd2;
      for (int i = 0; i < 3; i++) begin
         disp_req = 1'b1;
         #1;
         check("col_ready_low", host_ready, 0);
         check("col_mem_addr", mem_addr, 2);
         tick();
      end
      disp_req = 1'b0;
      #1;
      check("col_ready_high", host_ready, 1);
      check("col_disp_rdata", disp_rdata, 2);
      tick();
      host_valid = 1'b0;
      #1;
      check("col_host_rvalid", host_rvalid, 1);
      check("col_host_rdata", host_rdata, 7);
      check("col_stall_cnt", host_stall_cnt, EXP_STALL);
      tick();

      // Out-of-range host read and write.
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = 14'd12288;
      #1;
      check("oor_rd_ready", host_ready, 1);
      check("oor_rd_mem_en", mem_en, 0);
      tick();
      host_we    = 1'b1;
      host_addr  = 14'd12300;
      host_wdata = 3'b110;
      #1;
      check("oor_rd_rvalid", host_rvalid, 1);
      check("oor_rd_rdata", host_rdata, 0);
      check("oor_wr_ready", host_ready, 1);
      check("oor_wr_mem_en", mem_en, 0);
      tick();
      host_valid = 1'b0;
      #1;
      check("oor_wr_unchanged", vram[12300], 3'd4);
      check("oor_wr_no_rvalid", host_rvalid, 0);
      tick();

      // Full clear with display stealing every 5th cycle; restart attempt mid-clear.
      clr_value = 3'b111;
      clr_start = 1'b1;
      #1;
      check("clr_not_yet_busy", clr_busy, 0);
      tick();
      clr_start = 1'b0;
      clr_value = 3'b010;
      check("clr_busy_rise", clr_busy, 1);
      cyc      = 0;
      disp_cnt = 0;
      disp_addr = 14'd0;
      while (clr_busy && cyc < 20000) begin
         disp_req  = (cyc % 5 == 4);
         clr_start = (cyc == 6000);
         if (disp_req) disp_cnt++;
         tick();
         cyc++;
      end
      disp_req  = 1'b0;
      clr_start = 1'b0;
      check("clr_busy_cycles", cyc, 15359);
      check("clr_stolen_cycles", disp_cnt, 3071);
      check("clr_busy_fall", clr_busy, 0);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (vram[i] !== 3'b111) bad++;
      check("clr_fill_errors", bad, 0);
      check("clr_beyond_depth", vram[12289], 3'd1);
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = 14'd5;
      #1;
      check("clr_host_ready", host_ready, 1);
      tick();
      host_valid = 1'b0;
      #1;
      check("clr_host_rdata", host_rdata, 3'b111);
      tick();

      // Reset mid-clear at clr_addr 5000 with a display read in flight.
      preload();
      clr_value = 3'b011;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 5000; i++) tick();
      disp_req  = 1'b1;
      disp_addr = 14'd20;
      #1;
      check("rmc_mem_addr_disp", mem_addr, 20);
      tick();
      disp_req = 1'b0;
      reset    = 1'b1;
      #1;
      check("rmc_clr_busy", clr_busy, 0);
      check("rmc_disp_rvalid", disp_rvalid, 0);
      check("rmc_host_rvalid", host_rvalid, 0);
      check("rmc_mem_en", mem_en, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      bad = 0;
      for (int i = 0; i < 5000; i++) if (vram[i] !== 3'b011) bad++;
      check("rmc_cleared_part", bad, 0);
      bad = 0;
      for (int i = 5000; i < DEPTH; i++) if (vram[i] !== DATA_W'(i)) bad++;
      check("rmc_untouched_part", bad, 0);

      // New clear restarts from address 0.
      clr_value = 3'b110;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      #1;
      check("restart_mem_addr0", mem_addr, 0);
      check("restart_mem_wdata", mem_wdata, 3'b110);
      tick();
      tick();
      tick();
      check("restart_addr0", vram[0], 3'b110);
      check("restart_addr2", vram[2], 3'b110);
      check("restart_addr3_old", vram[3], 3'b011);
      check("restart_mem_addr3", mem_addr, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
